// File: rtl/tpu_quant_pkg.sv
// Shared quantization constants and the dequant-reader FSM state type.
//   DEQ_FRAC_BITS : fractional bits of the Q8.8 scale
//   DEQ_ROUND     : half an LSB of the scaled product (round-half-up bias)
//   deq_state_e   : burst controller states
package tpu_quant_pkg;

  localparam int DEQ_FRAC_BITS = 8;
  localparam int DEQ_ROUND     = 128;  // 1 << (DEQ_FRAC_BITS - 1)

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } deq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count.
//   clk, reset     : clock, synchronous active-high reset
//   wr_en_i/wr_data_i : push (dropped only if full and not popping)
//   rd_en_i        : pop head entry when not empty
//   rd_data_o      : head entry, forced to zero while empty
//   empty_o        : no entries stored
//   count_o        : number of stored entries, 0..DEPTH
// A write and a read in the same cycle are both served even when full.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             full, do_wr, do_rd;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_rd   = rd_en_i && !empty_o;
  assign do_wr   = wr_en_i && (!full || do_rd);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W+1)'(do_wr) - (PTR_W+1)'(do_rd);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, and an unreset array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/ub_dequant_reader.sv
// Burst reader: fetches int8 elements from the unified buffer, dequantizes
// them as ((q - Z) * S + 128) >>> 8 and streams the 32-bit results out.
//   clk, reset                 : clock, synchronous active-high reset
//   start, base_addr, length   : burst request (sampled in IDLE only)
//   deq_scale, deq_zero_point  : Q8.8 scale S and zero point Z
//   ub_rd_en/ub_rd_addr        : UB read port, data returns one cycle later
//   ub_rd_data                 : returned int8 element
//   out_valid/out_ready/out_data : result stream
//   busy, done                 : status; done pulses once per burst
module ub_dequant_reader
  import tpu_quant_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [15:0]       deq_scale,
  input  logic [7:0]        deq_zero_point,
  output logic              ub_rd_en,
  output logic [ADDR_W-1:0] ub_rd_addr,
  input  logic [7:0]        ub_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  deq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [15:0]       scale_q, scale_d;
  logic [7:0]        zp_q, zp_d;
  logic [CNT_W-1:0]  in_flight_q, fifo_count;
  logic              credit_ok, pop, fifo_empty;

  // Pipeline: rd_v (data on ub_rd_data) -> s1 (q) -> s2 (diff) -> s3 (prod).
  logic               rd_v_q, s1_v_q, s2_v_q, s3_v_q;
  logic signed [7:0]  s1_q;
  logic signed [8:0]  diff_q;
  logic signed [24:0] prod_q;
  logic signed [24:0] rounded, scaled;
  logic [31:0]        fifo_wr_data;

  // Every issued read owns a FIFO slot until it is popped, so the FIFO can
  // never overflow no matter how long out_ready stays low.
  assign credit_ok = ({1'b0, in_flight_q} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH);
  assign pop       = out_valid && out_ready;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    scale_d  = scale_q;
    zp_d     = zp_q;
    ub_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = length;
          scale_d  = deq_scale;
          zp_d     = deq_zero_point;
          state_d  = (length == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (credit_ok) begin
          ub_rd_en = 1'b1;
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - (ADDR_W+1)'(1);
          if (remain_q == (ADDR_W+1)'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave on the cycle the final element is popped so done follows it.
        if (in_flight_q == '0 &&
            (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop)))
          state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      scale_q     <= '0;
      zp_q        <= '0;
      in_flight_q <= '0;
      rd_v_q      <= 1'b0;
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      s3_v_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      scale_q     <= scale_d;
      zp_q        <= zp_d;
      // Issue and FIFO write may coincide; the net change covers both.
      in_flight_q <= in_flight_q + CNT_W'(ub_rd_en) - CNT_W'(s3_v_q);
      rd_v_q      <= ub_rd_en;
      s1_v_q      <= rd_v_q;
      s2_v_q      <= s1_v_q;
      s3_v_q      <= s2_v_q;
    end
  end

  // Datapath registers carry no reset; the valid bits above qualify them.
  always_ff @(posedge clk) begin
    s1_q   <= ub_rd_data;
    diff_q <= $signed({s1_q[7], s1_q}) - $signed({zp_q[7], zp_q});
    prod_q <= $signed({{16{diff_q[8]}}, diff_q}) * $signed({{9{scale_q[15]}}, scale_q});
  end

  // |prod| < 2^23, so the rounding bias cannot overflow 25 bits.
  assign rounded      = prod_q + 25'(DEQ_ROUND);
  assign scaled       = rounded >>> DEQ_FRAC_BITS;
  assign fifo_wr_data = {{7{scaled[24]}}, scaled};

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (s3_v_q),
    .wr_data_i (fifo_wr_data),
    .rd_en_i   (out_ready),
    .rd_data_o (out_data),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign out_valid  = !fifo_empty;
  assign ub_rd_addr = addr_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_ub_dequant_reader.sv
module tb_ub_dequant_reader;

  logic        clk = 1'b0;
  logic        reset, start, ub_rd_en, out_valid, out_ready, busy, done;
  logic [7:0]  base_addr, ub_rd_addr, ub_rd_data, deq_zero_point;
  logic [8:0]  length;
  logic [15:0] deq_scale;
  logic [31:0] out_data;

  ub_dequant_reader #(.ADDR_W(8), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .deq_scale(deq_scale), .deq_zero_point(deq_zero_point),
    .ub_rd_en(ub_rd_en), .ub_rd_addr(ub_rd_addr), .ub_rd_data(ub_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int     n_checks = 0, n_err = 0;
  int     cyc = 0;
  byte    ub_mem [256];
  longint exp_q[$];
  int     exp_addr_q[$];
  int     reads_burst, done_cnt = 0, ready_mode = 0;
  int     start_cyc, last_xfer_cyc, first_rd_cyc, first_valid_cyc;
  logic   prev_stall = 1'b0;
  longint prev_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Unified buffer: data valid exactly one cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    if (ub_rd_en) ub_rd_data <= ub_mem[ub_rd_addr];
    else          ub_rd_data <= 8'($urandom);
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 9) < 7);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: dequantized value straight from the arithmetic definition.
  function automatic longint model(input int q, input int z, input int s);
    longint p;
    p = longint'(q - z) * longint'(s);
    return (p + 128) >>> 8;  // floor((p + 128) / 256)
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", longint'($signed(out_data)), prev_data);
      end
      if (ub_rd_en) begin
        reads_burst++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (exp_addr_q.size() == 0) flag("unexpected_read");
        else check("rd_addr", ub_rd_addr, exp_addr_q.pop_front());
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        last_xfer_cyc = cyc;
        if (exp_q.size() == 0) flag("unexpected_output");
        else check("out_data", longint'($signed(out_data)), exp_q.pop_front());
      end
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = longint'($signed(out_data));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_burst(input int base, input int len, input int s, input int z);
    for (int i = 0; i < len; i++) exp_addr_q.push_back((base + i) & 255);
    reads_burst     = 0;
    first_rd_cyc    = -1;
    first_valid_cyc = -1;
    base_addr       = 8'(base);
    length          = 9'(len);
    deq_scale       = 16'(s);
    deq_zero_point  = 8'(z);
    start           = 1'b1;
    start_cyc       = cyc;
    tick();
    start          = 1'b0;
    // Scramble inputs: the burst must use the values captured at start.
    base_addr      = 8'($urandom);
    length         = 9'($urandom);
    deq_scale      = 16'($urandom);
    deq_zero_point = 8'($urandom);
  endtask

  task automatic wait_done(input int len);
    int done_at;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen    = 1'b1;
        done_at = cyc;
      end
    end
    if (!seen) begin
      flag("done_timeout");
    end else begin
      check("done_timing", done_at, (len == 0) ? start_cyc + 1 : last_xfer_cyc + 1);
      check("read_count", reads_burst, len);
      check("all_received", exp_q.size(), 0);
      @(negedge clk);
      check("idle_after_done", busy, 0);
    end
    tick();
  endtask

  task automatic run_directed(input int base, input int q, input int z, input int s,
                              input longint expected);
    ub_mem[base] = byte'(q);
    exp_q.push_back(expected);
    start_burst(base, 1, s, z);
    wait_done(1);
  endtask

  task automatic run_random(input int base, input int len);
    int s, z;
    s = $signed(16'($urandom));
    z = $signed(8'($urandom));
    for (int i = 0; i < len; i++)
      exp_q.push_back(model(ub_mem[(base + i) & 255], z, s));
    start_burst(base, len, s, z);
    wait_done(len);
  endtask

  initial begin
    int d0;
    bit hit;
    for (int i = 0; i < 256; i++) ub_mem[i] = byte'($urandom);
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    deq_scale = '0; deq_zero_point = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", ub_rd_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single element: value and 5-cycle latency.
    ready_mode = 0;
    run_directed(8'h10, 10, 2, 16'h0180, 12);
    check("latency", first_valid_cyc - first_rd_cyc, 5);

    // Extremes and round-half-up on a negative half.
    run_directed(8'h33, -128, 127, 16'h7FFF, -32639);
    run_directed(8'h34, -1, 0, 16'h0080, 0);

    // Address wrap-around.
    run_random(8'hFE, 4);

    // Backpressure: credit limits reads to the FIFO depth.
    ready_mode = 2;
    tick();
    begin
      int s, z;
      s = $signed(16'($urandom));
      z = $signed(8'($urandom));
      for (int i = 0; i < 16; i++) exp_q.push_back(model(ub_mem[(8'h40 + i) & 255], z, s));
      start_burst(8'h40, 16, s, z);
      repeat (30) @(negedge clk);
      check("stall_reads", reads_burst, 8);
      ready_mode = 0;
      wait_done(16);
    end

    // Zero length: done on the next cycle, no reads.
    start_burst(8'h20, 0, 16'h0100, 0);
    wait_done(0);

    // Start while busy is ignored.
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back(model(ub_mem[8'h50 + i], 3, 16'h0200));
    start_burst(8'h50, 5, 16'h0200, 3);
    tick();
    base_addr = 8'h90; length = 9'd7; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(5);
    repeat (10) tick();
    check("busy_start_ignored", done_cnt - d0, 1);

    // Reset mid-burst aborts cleanly.
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) exp_q.push_back(model(ub_mem[8'h60 + i], 0, 16'h0100));
    start_burst(8'h60, 10, 16'h0100, 0);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (reads_burst >= 3) hit = 1'b1;
    end
    if (!hit) flag("abort_reads_timeout");
    reset = 1'b1;
    repeat (2) tick();
    exp_q.delete();
    exp_addr_q.delete();
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    repeat (12) @(negedge clk);
    check("abort_valid_later", out_valid, 0);
    check("abort_no_done", done_cnt - d0, 0);
    tick();
    run_random(8'h70, 2);

    // Randomized bursts under random backpressure.
    ready_mode = 1;
    for (int n = 0; n < 8; n++) run_random($urandom_range(0, 255), $urandom_range(1, 20));
    ready_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ub_dequant_reader.md
UB_DEQUANT_READER -- requirements
Module: ub_dequant_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: unified-buffer (UB) address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: output FIFO entries, power of two, at least 4.
REQ-003 SHALL have ports `clk  in  1  clock`, with reset reset, synchronous, active-high, on clock clk.
REQ-004 SHALL have port `reset  in  1  synchronous active-high reset`.
REQ-005 SHALL have port `start  in  1  begin a burst; sampled only in IDLE`.
REQ-006 SHALL have port `base_addr  in  ADDR_W  first UB address of the burst`.
REQ-007 SHALL have port `length  in  ADDR_W+1  element count, 0..2^ADDR_W`.
REQ-008 SHALL have port `deq_scale  in  16  signed scale S, Q8.8`.
REQ-009 SHALL have port `deq_zero_point  in  8  signed zero point Z`.
REQ-010 SHALL have port `ub_rd_en  out  1  UB read strobe`.
REQ-011 SHALL have port `ub_rd_addr  out  ADDR_W  UB read address`.
REQ-012 SHALL have port `ub_rd_data  in  8  signed int8, valid exactly 1 cycle after ub_rd_en`.
REQ-013 SHALL have port `out_valid  out  1  out_data is valid`.
REQ-014 SHALL have port `out_ready  in  1  consumer accepts`.
REQ-015 SHALL have port `out_data  out  32  signed dequantized value`.
REQ-016 SHALL have port `busy  out  1  high in every state except IDLE`.
REQ-017 SHALL have port `done  out  1  one-cycle pulse at burst completion`.

Function
REQ-018 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE:
- IDLE→RUN on start with length≠0.
- IDLE→DONE on start with length=0.
- RUN→DRAIN in the cycle after the last read is issued.
- DRAIN→DONE when the pipeline is empty and the last element has been accepted.
- DONE→IDLE unconditionally.
REQ-019 SHALL capture base_addr, length, deq_scale and deq_zero_point at start; later input changes SHALL NOT affect the burst in progress.
REQ-020 SHALL ignore start while busy is high.
REQ-021 SHALL issue read addresses base_addr, base_addr+1, …, incrementing modulo 2^ADDR_W (wrap-around), with at most one read per cycle.
REQ-022 SHALL assert ub_rd_en in RUN only when in_flight + fifo_count < FIFO_DEPTH; this credit rule guarantees the FIFO never overflows and no element is dropped under backpressure.
REQ-023 SHALL process data through the following pipeline:
- stage 1: register ub_rd_data.
- stage 2: diff = q − Z, 9-bit signed.
- stage 3: prod = diff × S, 25-bit signed.
- stage 4: res = (prod + 128) >>> 8 (arithmetic shift, round-half-up), sign-extended to 32 bits and written to the FIFO.
REQ-024 SHALL produce out_valid 5 cycles after ub_rd_en (latency 5) when the FIFO is empty and out_ready is high.
REQ-025 SHALL require no saturation; the full-range result fits in 18 bits.
REQ-026 SHALL deliver outputs in issue order, with exactly `length` transfers (out_valid & out_ready) per burst.
REQ-027 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-028 SHALL pulse done in the DONE state only, one cycle after the final transfer (or one cycle after start when length=0).
REQ-029 SHALL serve a FIFO write and read in the same cycle when the FIFO is full: the read frees the slot and fifo_count is unchanged.
REQ-030 SHALL keep in_flight and the credit check consistent when a read issue and a FIFO write occur in the same cycle.

Reset
REQ-031 SHALL place the FSM in IDLE on reset.
REQ-032 SHALL drive busy, done, ub_rd_en and out_valid to 0 and out_data to 0 on reset.
REQ-033 SHALL clear the FIFO, in_flight, the address counter and all pipeline valid bits on reset.
REQ-034 SHALL abort a burst when reset is asserted mid-burst: no further reads, no done pulse, and no stale outputs after reset is released.

Structure
REQ-035 SHALL place the constants DEQ_FRAC_BITS=8 and DEQ_ROUND=128 and the FSM state enum in the shared package tpu_quant_pkg.
REQ-036 SHALL implement the output buffer as one sub-module, sync_fifo (parameters WIDTH=32, DEPTH=FIFO_DEPTH), with a count output.
REQ-037 SHALL infer the multiply from registered operands and a registered result, suitable for DSP mapping.

Verification
REQ-038 SHALL cover: base 0x10, len 1, q=10, Z=2, S=0x0180 → out_data=12, out_valid exactly 5 cycles after ub_rd_en, then done.
REQ-039 SHALL cover: q=−128, Z=127, S=0x7FFF → −32639; q=−1, Z=0, S=0x0080 → 0 (round-half-up).
REQ-040 SHALL cover: base 0xFE, len 4 → ub_rd_addr 0xFE, 0xFF, 0x00, 0x01; four ordered outputs.
REQ-041 SHALL cover: len 16, out_ready=0 for 30 cycles → exactly 8 reads issued and all 16 values received in order after release.
REQ-042 SHALL cover: start with len 0 → done pulse next cycle, no ub_rd_en; start pulsed while busy → ignored.
REQ-043 SHALL cover: reset asserted after 3 reads of a len-10 burst → IDLE, out_valid=0, no done; a new len-2 burst completes correctly.
